// File: rtl/sramgen_sram_march_bist.sv
// sramgen_sram_march_bist: March C- built-in self-test initiator for a sramgen
// single-port SRAM macro. Issues one macro operation per cycle and compares
// read data two edges after the read is driven (macro dout is registered).
// Optional feature: define SRAM_BIST_ERRLOG_EN to add err_addr/err_data/err_count.
module sramgen_sram_march_bist #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WMASK_WIDTH = 4,
    parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] BG_PATTERN = {DATA_WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
`ifdef SRAM_BIST_ERRLOG_EN
    ,
    output logic [ADDR_WIDTH-1:0]  err_addr,
    output logic [DATA_WIDTH-1:0]  err_data,
    output logic [15:0]            err_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  state_q, state_d;
    logic [2:0]              elem_q, elem_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    phase_q, phase_d;
    logic                    fail_q, fail_d;
    logic                    sram_we_d;
    logic [WMASK_WIDTH-1:0]  sram_wmask_d;
    logic [ADDR_WIDTH-1:0]   sram_addr_d;
    logic [DATA_WIDTH-1:0]   sram_din_d;
    logic                    sram_we_q;
    logic [WMASK_WIDTH-1:0]  sram_wmask_q;
    logic [ADDR_WIDTH-1:0]   sram_addr_q;
    logic [DATA_WIDTH-1:0]   sram_din_q;
    logic                    cmp_valid_q, cmp_valid_d;
    logic [DATA_WIDTH-1:0]   exp_q, exp_d;
    logic                    cmp_valid2_q, cmp_valid2_d;
    logic [DATA_WIDTH-1:0]   exp2_q, exp2_d;
    logic                    accept, two_op, down, next_down, miscompare;
    logic [ADDR_WIDTH-1:0]   elem_last;

    assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
    assign two_op     = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    assign down       = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign next_down  = (elem_q == 3'd2) || (elem_q == 3'd3);
    assign elem_last  = down ? '0 : LAST_ADDR;
    assign miscompare = cmp_valid2_q && (sram_dout !== exp2_q);

    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign fail       = fail_q;
    assign sram_we    = sram_we_q;
    assign sram_wmask = sram_wmask_q;
    assign sram_addr  = sram_addr_q;
    assign sram_din   = sram_din_q;

    // Sequencer: walks elements e0..e5, addresses and read/write phase
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        fail_d  = fail_q | miscompare;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = RUN;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            RUN: begin
                if (two_op && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == elem_last) begin
                        if (elem_q == 3'd5) begin
                            state_d = DRAIN;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            addr_d = next_down ? LAST_ADDR : '0;
                        end
                    end else if (down) begin
                        addr_d = addr_q - ADDR_WIDTH'(1);
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Operation decode for the op issued at the coming edge, plus compare pipeline
    always_comb begin
        sram_we_d    = 1'b0;
        sram_wmask_d = '0;
        sram_addr_d  = '0;
        sram_din_d   = '0;
        cmp_valid_d  = 1'b0;
        exp_d        = '0;
        cmp_valid2_d = cmp_valid_q;
        exp2_d       = exp_q;
        if (state_d == RUN) begin
            sram_addr_d = addr_d;
            if ((elem_d == 3'd0) || phase_d) begin
                sram_we_d    = 1'b1;
                sram_wmask_d = '1;
                sram_din_d   = ((elem_d == 3'd1) || (elem_d == 3'd3)) ? ~BG_PATTERN : BG_PATTERN;
            end else begin
                cmp_valid_d = 1'b1;
                exp_d       = ((elem_d == 3'd2) || (elem_d == 3'd4)) ? ~BG_PATTERN : BG_PATTERN;
            end
        end
    end

    // State, counters, macro port and compare pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            elem_q       <= 3'd0;
            addr_q       <= '0;
            phase_q      <= 1'b0;
            fail_q       <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_wmask_q <= '0;
            sram_addr_q  <= '0;
            sram_din_q   <= '0;
            cmp_valid_q  <= 1'b0;
            exp_q        <= '0;
            cmp_valid2_q <= 1'b0;
            exp2_q       <= '0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            addr_q       <= addr_d;
            phase_q      <= phase_d;
            fail_q       <= fail_d;
            sram_we_q    <= sram_we_d;
            sram_wmask_q <= sram_wmask_d;
            sram_addr_q  <= sram_addr_d;
            sram_din_q   <= sram_din_d;
            cmp_valid_q  <= cmp_valid_d;
            exp_q        <= exp_d;
            cmp_valid2_q <= cmp_valid2_d;
            exp2_q       <= exp2_d;
        end
    end

`ifdef SRAM_BIST_ERRLOG_EN
    logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [DATA_WIDTH-1:0] err_data_q, err_data_d;
    logic [15:0]           err_count_q, err_count_d;

    assign err_addr  = err_addr_q;
    assign err_data  = err_data_q;
    assign err_count = err_count_q;

    // Error log: first miscompare address/data and a saturating miscompare count
    always_comb begin
        addr2_d     = sram_addr_q;
        err_addr_d  = err_addr_q;
        err_data_d  = err_data_q;
        err_count_d = err_count_q;
        if (accept) begin
            err_addr_d  = '0;
            err_data_d  = '0;
            err_count_d = '0;
        end else if (miscompare) begin
            if (err_count_q == 16'd0) begin
                err_addr_d = addr2_q;
                err_data_d = sram_dout;
            end
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    // Error log registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr2_q     <= '0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
            err_count_q <= '0;
        end else begin
            addr2_q     <= addr2_d;
            err_addr_q  <= err_addr_d;
            err_data_q  <= err_data_d;
            err_count_q <= err_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_sramgen_sram_march_bist.sv
// Testbench for sramgen_sram_march_bist: a default-size instance with a
// behavioural macro model (port trace, stuck-at faults, reset, ignored starts)
// and a small instance run with randomised faults against a March C- model.
// Error-log outputs are checked when SRAM_BIST_ERRLOG_EN is defined.
module tb_sramgen_sram_march_bist;

   localparam int BIG_N   = 1024;
   localparam int SMALL_N = 16;
   localparam int NTRACE  = 14;

   logic clk = 1'b0;
   logic rst;

   logic        bigStart, bigBusy, bigDone, bigFail, bigWe;
   logic [3:0]  bigWmask;
   logic [9:0]  bigAddr;
   logic [31:0] bigDin, bigDout, bigRead;
   logic [31:0] bigMem [0:BIG_N-1];

   logic        smallStart, smallBusy, smallDone, smallFail, smallWe;
   logic [1:0]  smallWmask;
   logic [3:0]  smallAddr;
   logic [7:0]  smallDin, smallDout, smallRead;
   logic [7:0]  smallMem [0:SMALL_N-1];

`ifdef SRAM_BIST_ERRLOG_EN
   logic [9:0]  bigErrAddr;
   logic [31:0] bigErrData;
   logic [15:0] bigErrCount;
   logic [3:0]  smallErrAddr;
   logic [7:0]  smallErrData;
   logic [15:0] smallErrCount;
`endif

   bit bigFaultEn, bigFaultVal, smallFaultEn, smallFaultVal;
   int bigFaultAddr, bigFaultBit, smallFaultAddr, smallFaultBit;

   int testsRun = 0;
   int failures = 0;

   typedef struct {
      int          cyc;
      logic        we;
      logic [3:0]  wmask;
      logic [9:0]  addr;
      logic [31:0] din;
      logic        busy;
   } traceVec_t;

   traceVec_t traceTab [NTRACE];

   always #5 clk = ~clk;

   sramgen_sram_march_bist uBig (
      .clk        (clk),
      .rst        (rst),
      .start      (bigStart),
      .busy       (bigBusy),
      .done       (bigDone),
      .fail       (bigFail),
      .sram_we    (bigWe),
      .sram_wmask (bigWmask),
      .sram_addr  (bigAddr),
      .sram_din   (bigDin),
      .sram_dout  (bigDout)
`ifdef SRAM_BIST_ERRLOG_EN
      ,
      .err_addr   (bigErrAddr),
      .err_data   (bigErrData),
      .err_count  (bigErrCount)
`endif
   );

   sramgen_sram_march_bist #(
      .DATA_WIDTH  (8),
      .ADDR_WIDTH  (4),
      .WMASK_WIDTH (2),
      .BG_PATTERN  (8'hA5)
   ) uSmall (
      .clk        (clk),
      .rst        (rst),
      .start      (smallStart),
      .busy       (smallBusy),
      .done       (smallDone),
      .fail       (smallFail),
      .sram_we    (smallWe),
      .sram_wmask (smallWmask),
      .sram_addr  (smallAddr),
      .sram_din   (smallDin),
      .sram_dout  (smallDout)
`ifdef SRAM_BIST_ERRLOG_EN
      ,
      .err_addr   (smallErrAddr),
      .err_data   (smallErrData),
      .err_count  (smallErrCount)
`endif
   );

   // Macro read path with an optional stuck-at cell
   assign bigRead = (bigFaultEn && (int'(bigAddr) == bigFaultAddr))
                  ? ((bigMem[bigAddr] & ~(32'h1 << bigFaultBit)) | (32'(bigFaultVal) << bigFaultBit))
                  : bigMem[bigAddr];
   assign smallRead = (smallFaultEn && (int'(smallAddr) == smallFaultAddr))
                    ? ((smallMem[smallAddr] & ~(8'h1 << smallFaultBit)) | (8'(smallFaultVal) << smallFaultBit))
                    : smallMem[smallAddr];

   // Single-port macro models: masked write, registered read, dout undefined on writes
   always @(posedge clk) begin
      if (bigWe) begin
         for (int l = 0; l < 4; l++)
            if (bigWmask[l]) bigMem[bigAddr][l*8 +: 8] <= bigDin[l*8 +: 8];
         bigDout <= 'x;
      end else begin
         bigDout <= bigRead;
      end
   end

   always @(posedge clk) begin
      if (smallWe) begin
         for (int l = 0; l < 2; l++)
            if (smallWmask[l]) smallMem[smallAddr][l*4 +: 4] <= smallDin[l*4 +: 4];
         smallDout <= 'x;
      end else begin
         smallDout <= smallRead;
      end
   end

   // Compare one value against its expectation and log a failure line
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // March C- reference: element list walked over an array with a stuck-at cell
   task automatic marchModel(input int depth, input int width, input logic [31:0] bg,
                             input bit fen, input int fa, input int fb, input bit fv,
                             output bit eFail, output logic [31:0] eAddr,
                             output logic [31:0] eData, output int eCount);
      logic [31:0] mem [0:1023];
      logic [31:0] mask, got, want;
      int rdSel [6] = '{-1, 0, 1, 0, 1, 0};
      int wrSel [6] = '{0, 1, 0, 1, 0, -1};
      bit dn [6]    = '{0, 0, 0, 1, 1, 0};
      int a;
      mask   = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
      eFail  = 1'b0;
      eAddr  = '0;
      eData  = '0;
      eCount = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < depth; i++) begin
            a = dn[e] ? (depth - 1 - i) : i;
            if (rdSel[e] >= 0) begin
               want = ((rdSel[e] == 1) ? ~bg : bg) & mask;
               got  = mem[a];
               if (fen && (a == fa)) got[fb] = fv;
               if (got !== want) begin
                  if (eCount == 0) begin
                     eAddr = 32'(a);
                     eData = got;
                  end
                  eCount++;
                  eFail = 1'b1;
               end
            end
            if (wrSel[e] >= 0) mem[a] = ((wrSel[e] == 1) ? ~bg : bg) & mask;
         end
      end
   endtask

   // Run one full test on the default-size instance and check the outcome
   task automatic applyStimulus(input string tag, input bit doTrace, input bit doIgnored);
      bit eFail;
      logic [31:0] eAddr, eData;
      int eCount, c, busyCnt, ti;
      marchModel(BIG_N, 32, 32'h0, bigFaultEn, bigFaultAddr, bigFaultBit, bigFaultVal,
                 eFail, eAddr, eData, eCount);
      @(negedge clk);
      bigStart = 1'b1;
      @(negedge clk);
      bigStart = 1'b0;
      checkOutput($sformatf("%s accept busy/done/fail", tag), 64'({bigBusy, bigDone, bigFail}), 64'b100);
      c = 1;
      busyCnt = 0;
      ti = 0;
      while (!bigDone && (c <= 10*BIG_N + 20)) begin
         if (bigBusy) busyCnt++;
         if (doTrace && (ti < NTRACE) && (traceTab[ti].cyc == c)) begin
            checkOutput($sformatf("%s trace cycle %0d", tag, c),
                        64'({bigWe, bigWmask, bigAddr, bigDin, bigBusy}),
                        64'({traceTab[ti].we, traceTab[ti].wmask, traceTab[ti].addr,
                             traceTab[ti].din, traceTab[ti].busy}));
            ti++;
         end
         if (doIgnored && ((c == 100) || (c == 5000) || (c == 10*BIG_N + 1))) bigStart = 1'b1;
         @(negedge clk);
         bigStart = 1'b0;
         c++;
      end
      if (doTrace) checkOutput($sformatf("%s trace points seen", tag), 64'(ti), 64'(NTRACE));
      checkOutput($sformatf("%s busy cycles", tag), 64'(busyCnt), 64'(10*BIG_N + 1));
      checkOutput($sformatf("%s done/busy at end", tag), 64'({bigDone, bigBusy}), 64'b10);
      checkOutput($sformatf("%s fail", tag), 64'(bigFail), 64'(eFail));
`ifdef SRAM_BIST_ERRLOG_EN
      checkOutput($sformatf("%s err_count", tag), 64'(bigErrCount), 64'((eCount > 65535) ? 65535 : eCount));
      checkOutput($sformatf("%s err_addr", tag), 64'(bigErrAddr), 64'(eAddr[9:0]));
      checkOutput($sformatf("%s err_data", tag), 64'(bigErrData), 64'(eData));
`endif
      if (doIgnored) begin
         @(negedge clk);
         checkOutput($sformatf("%s start on done edge ignored", tag), 64'({bigDone, bigBusy}), 64'b10);
      end
   endtask

   initial begin
      bit eFail;
      logic [31:0] eAddr, eData;
      int eCount, c, busyCnt;

      traceTab[0]  = '{1,           1'b1, 4'hF, 10'd0,    32'h0,         1'b1};
      traceTab[1]  = '{2,           1'b1, 4'hF, 10'd1,    32'h0,         1'b1};
      traceTab[2]  = '{1024,        1'b1, 4'hF, 10'd1023, 32'h0,         1'b1};
      traceTab[3]  = '{1025,        1'b0, 4'h0, 10'd0,    32'h0,         1'b1};
      traceTab[4]  = '{1026,        1'b1, 4'hF, 10'd0,    32'hFFFF_FFFF, 1'b1};
      traceTab[5]  = '{1027,        1'b0, 4'h0, 10'd1,    32'h0,         1'b1};
      traceTab[6]  = '{3*BIG_N + 1, 1'b0, 4'h0, 10'd0,    32'h0,         1'b1};
      traceTab[7]  = '{3*BIG_N + 2, 1'b1, 4'hF, 10'd0,    32'h0,         1'b1};
      traceTab[8]  = '{5*BIG_N + 1, 1'b0, 4'h0, 10'd1023, 32'h0,         1'b1};
      traceTab[9]  = '{5*BIG_N + 2, 1'b1, 4'hF, 10'd1023, 32'hFFFF_FFFF, 1'b1};
      traceTab[10] = '{5*BIG_N + 3, 1'b0, 4'h0, 10'd1022, 32'h0,         1'b1};
      traceTab[11] = '{9*BIG_N + 1, 1'b0, 4'h0, 10'd0,    32'h0,         1'b1};
      traceTab[12] = '{10*BIG_N,    1'b0, 4'h0, 10'd1023, 32'h0,         1'b1};
      traceTab[13] = '{10*BIG_N+1,  1'b0, 4'h0, 10'd0,    32'h0,         1'b1};

      rst = 1'b1;
      bigStart = 1'b0;
      smallStart = 1'b0;
      bigFaultEn = 1'b0;
      smallFaultEn = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset big outputs", 64'({bigBusy, bigDone, bigFail, bigWe, bigWmask, bigAddr, bigDin}), 64'h0);
      checkOutput("reset small outputs", 64'({smallBusy, smallDone, smallFail, smallWe, smallWmask, smallAddr, smallDin}), 64'h0);
      rst = 1'b0;

      applyStimulus("clean+trace", 1'b1, 1'b0);

      bigFaultEn = 1'b1;
      bigFaultAddr = 5;
      bigFaultBit = 3;
      bigFaultVal = 1'b0;
      applyStimulus("sa0 mem[5][3]", 1'b0, 1'b0);

      bigFaultEn = 1'b0;
      applyStimulus("restart after failing run", 1'b0, 1'b0);

      bigFaultEn = 1'b1;
      bigFaultAddr = $urandom_range(0, BIG_N - 1);
      bigFaultBit = $urandom_range(0, 31);
      bigFaultVal = 1'(($urandom_range(0, 1)));
      applyStimulus("random fault, ignored starts", 1'b0, 1'b1);

      // Reset in the middle of a run aborts everything immediately
      bigFaultEn = 1'b0;
      @(negedge clk);
      bigStart = 1'b1;
      @(negedge clk);
      bigStart = 1'b0;
      repeat (2999) @(negedge clk);
      checkOutput("busy before mid-run reset", 64'(bigBusy), 64'(1));
      rst = 1'b1;
      #1;
      checkOutput("mid-run reset outputs", 64'({bigBusy, bigDone, bigFail, bigWe, bigWmask, bigAddr, bigDin}), 64'h0);
`ifdef SRAM_BIST_ERRLOG_EN
      checkOutput("mid-run reset errlog", 64'({bigErrAddr, bigErrCount}), 64'h0);
`endif
      @(negedge clk);
      rst = 1'b0;
      applyStimulus("run after reset", 1'b0, 1'b0);

      // Randomised faults and start noise on the small instance
      for (int r = 0; r < 30; r++) begin
         smallFaultEn = ($urandom_range(0, 3) != 0);
         smallFaultAddr = $urandom_range(0, SMALL_N - 1);
         smallFaultBit = $urandom_range(0, 7);
         smallFaultVal = 1'(($urandom_range(0, 1)));
         marchModel(SMALL_N, 8, 32'hA5, smallFaultEn, smallFaultAddr, smallFaultBit, smallFaultVal,
                    eFail, eAddr, eData, eCount);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         smallStart = 1'b1;
         @(negedge clk);
         smallStart = 1'b0;
         checkOutput($sformatf("small run %0d accept", r), 64'({smallBusy, smallDone, smallFail}), 64'b100);
         c = 1;
         busyCnt = 0;
         while (!smallDone && (c <= 10*SMALL_N + 20)) begin
            if (smallBusy) busyCnt++;
            smallStart = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            c++;
         end
         smallStart = 1'b0;
         checkOutput($sformatf("small run %0d busy cycles", r), 64'(busyCnt), 64'(10*SMALL_N + 1));
         checkOutput($sformatf("small run %0d fail", r), 64'({smallDone, smallFail}), 64'({1'b1, eFail}));
`ifdef SRAM_BIST_ERRLOG_EN
         checkOutput($sformatf("small run %0d errlog", r), 64'({smallErrAddr, smallErrData, smallErrCount}),
                     64'({eAddr[3:0], eData[7:0], 16'(eCount)}));
`endif
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
